// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game core: state codes, the FSM state type, and small
// elaboration-time helpers (ceiling log2, one-hot expansion, Galois LFSR feedback masks).
package simon_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_ADD   = 3'd1;
  localparam logic [STATE_W-1:0] S_SHOW  = 3'd2;
  localparam logic [STATE_W-1:0] S_GAP   = 3'd3;
  localparam logic [STATE_W-1:0] S_INPUT = 3'd4;
  localparam logic [STATE_W-1:0] S_FAIL  = 3'd5;
  localparam logic [STATE_W-1:0] S_WIN   = 3'd6;

  // Code 7 has no enumerator; the engine decodes it as idle.
  typedef enum logic [STATE_W-1:0] {
    StIdle  = S_IDLE,
    StAdd   = S_ADD,
    StShow  = S_SHOW,
    StGap   = S_GAP,
    StInput = S_INPUT,
    StFail  = S_FAIL,
    StWin   = S_WIN
  } state_e;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  function automatic logic [63:0] onehot(input logic [5:0] idx);
    return 64'd1 << idx;
  endfunction

  // Right-shifting Galois feedback masks (top bit always set, so a non-zero
  // state can never shift to zero). Supported widths: 3..16.
  function automatic logic [15:0] lfsr_mask(input int unsigned width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

endpackage

// File: rtl/simon_engine_if.sv
// Board-facing signal bundle of the Simon engine.
//   btn       raw switches (asynchronous), driven by the board side
//   led       one-hot sequence display / win pattern
//   error_led high while in FAIL
//   win_led   high while in WIN
//   level     current sequence length
//   state     FSM state code for a debug display
// Modports: slave = engine side, master = board/testbench side.
interface simon_engine_if
  import simon_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LEN_W  = 5
);
  logic [NUM_CH-1:0]  btn;
  logic [NUM_CH-1:0]  led;
  logic               error_led;
  logic               win_led;
  logic [LEN_W-1:0]   level;
  logic [STATE_W-1:0] state;

  modport slave (
    input  btn,
    output led, error_led, win_led, level, state
  );

  modport master (
    output btn,
    input  led, error_led, win_led, level, state
  );
endinterface

// File: rtl/simon_input_sync.sv
// Switch front end: two-flop synchroniser, rising-edge detector and decode.
//   slow_clk  game tick clock
//   reset     asynchronous, active-high
//   btn       raw switches
//   press     at least one switch rose this cycle
//   valid     exactly one switch rose
//   val       index of the risen switch (meaningful when valid)
// A toggle on btn shows up on press two edges later, for exactly one cycle.
module simon_input_sync
  import simon_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = clog2(NUM_CH)
) (
  input  logic              slow_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn,
  output logic              press,
  output logic              valid,
  output logic [CH_W-1:0]   val
);
  logic [NUM_CH-1:0] sw0, sw1, sw_prev, rise;

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      sw0     <= '0;
      sw1     <= '0;
      sw_prev <= '0;
    end else begin
      sw0     <= btn;
      sw1     <= sw0;
      sw_prev <= sw1;
    end
  end

  assign rise  = sw1 & ~sw_prev;
  assign press = |rise;
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign valid = press && ((rise & (rise - NUM_CH'(1))) == '0);

  always_comb begin
    val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise[i]) val = CH_W'(i);
    end
  end
endmodule

// File: rtl/simon_engine.sv
// Simon game core: LFSR step source, sequence store and game FSM with registered outputs.
//   slow_clk  game tick clock, all flops on posedge
//   reset     asynchronous, active-high
//   bus       simon_engine_if.slave: btn in; led, error_led, win_led, level, state out
// Build option: define SIMON_TIMEOUT_EN to fail a round after TIMEOUT_TICKS idle INPUT cycles.
module simon_engine
  import simon_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned LFSR_W        = 8,
  parameter int unsigned TIMEOUT_TICKS = 8
) (
  input logic           slow_clk,
  input logic           reset,
  simon_engine_if.slave bus
);
  localparam int unsigned CH_W  = clog2(NUM_CH);
  localparam int unsigned LEN_W = clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = clog2(MAX_LEN);
  localparam logic [LFSR_W-1:0] LFSR_MASK = LFSR_W'(lfsr_mask(LFSR_W));

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]   mem [MAX_LEN];
  logic              mem_we;
  logic [LFSR_W-1:0] lfsr_q;
  logic [CH_W-1:0]   new_step, show_val;
  logic              press, valid, last;
  logic [CH_W-1:0]   val;
  logic [NUM_CH-1:0] led_q, led_d;
  logic              error_q, error_d, win_q, win_d;
  logic [LEN_W-1:0]  level_q, level_d;

`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned TMO_W = clog2(TIMEOUT_TICKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_TICKS);
`endif

  simon_input_sync #(
    .NUM_CH (NUM_CH)
  ) u_sync (
    .slow_clk (slow_clk),
    .reset    (reset),
    .btn      (bus.btn),
    .press    (press),
    .valid    (valid),
    .val      (val)
  );

  assign new_step = lfsr_q[CH_W-1:0];
  assign last     = (LEN_W'(idx_q) == len_q - LEN_W'(1));

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= LFSR_W'(1);
      led_q   <= '0;
      error_q <= 1'b0;
      win_q   <= 1'b0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lfsr_q  <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
      led_q   <= led_d;
      error_q <= error_d;
      win_q   <= win_d;
      level_q <= level_d;
    end
  end

  // Sequence store survives reset; every round rewrites the slot it extends.
  always_ff @(posedge slow_clk) begin
    if (mem_we) mem[len_q[IDX_W-1:0]] <= new_step;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    mem_we  = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StAdd;
          len_d   = '0;
        end
      end
      StAdd: begin
        mem_we  = 1'b1;
        len_d   = len_q + LEN_W'(1);
        idx_d   = '0;
        state_d = StShow;
      end
      StShow: state_d = StGap;
      StGap: begin
        if (last) begin
          idx_d   = '0;
          state_d = StInput;
`ifdef SIMON_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StShow;
        end
      end
      StInput: begin
        if (press) begin
          if (!valid || (val != mem[idx_q])) begin
            state_d = StFail;
          end else begin
`ifdef SIMON_TIMEOUT_EN
            tmo_d = '0;
`endif
            if (!last)                           idx_d   = idx_q + IDX_W'(1);
            else if (len_q == LEN_W'(MAX_LEN))   state_d = StWin;
            else                                 state_d = StAdd;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) state_d = StFail;
        else                        tmo_d   = tmo_q + TMO_W'(1);
`endif
      end
      StFail, StWin: begin
        if (press) begin
          state_d = StIdle;
          len_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        len_d   = '0;
      end
    endcase

    // Outputs follow the next state so they line up with state_q after the edge.
    // On the ADD->SHOW edge slot 0 may be written in the same cycle, so forward it.
    show_val = (mem_we && (idx_d == len_q[IDX_W-1:0])) ? new_step : mem[idx_d];
    led_d    = '0;
    error_d  = 1'b0;
    win_d    = 1'b0;
    level_d  = len_d;
    case (state_d)
      StIdle: level_d = '0;
      StShow: led_d = NUM_CH'(onehot(6'(show_val)));
      StFail: error_d = 1'b1;
      StWin: begin
        win_d   = 1'b1;
        led_d   = '1;
        level_d = LEN_W'(MAX_LEN);
      end
      default: ;
    endcase
  end

  assign bus.led       = led_q;
  assign bus.error_led = error_q;
  assign bus.win_led   = win_q;
  assign bus.level     = level_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_simon_engine.sv
// Self-checking bench for simon_engine (NUM_CH=4, MAX_LEN=4, TIMEOUT_TICKS=8).
// A reference LFSR predicts each new sequence step; shown LEDs and replay outcomes are
// checked against that sequence.
module tb_simon_engine;
  localparam int unsigned NumCh    = 4;
  localparam int unsigned MaxLen   = 4;
  localparam int unsigned LenW     = 3;
  localparam int unsigned TmoTicks = 8;

  logic slow_clk = 1'b0;
  logic reset    = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  logic [7:0] m_lfsr;
  logic [1:0] exp_seq[$];

  simon_engine_if #(.NUM_CH(NumCh), .LEN_W(LenW)) bus ();

  simon_engine #(
    .NUM_CH        (NumCh),
    .MAX_LEN       (MaxLen),
    .LFSR_W        (8),
    .TIMEOUT_TICKS (TmoTicks)
  ) dut (
    .slow_clk (slow_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 slow_clk = ~slow_clk;

  // Reference 8-bit Galois LFSR, polynomial mask 0xB8, seed 1, one step per tick.
  always @(posedge slow_clk or posedge reset) begin
    if (reset) m_lfsr <= 8'd1;
    else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  // A new step is appended in each ADD cycle; the sequence is forgotten in IDLE.
  always @(negedge slow_clk) begin
    if (bus.state == 3'd0)      exp_seq.delete();
    else if (bus.state == 3'd1) exp_seq.push_back(m_lfsr[1:0]);
  end

  task automatic press(input logic [3:0] v);
    bus.btn = v;
    @(negedge slow_clk);
    bus.btn = '0;
    @(negedge slow_clk);
    @(negedge slow_clk);
  endtask

  // Called at the ADD negedge; collects SHOW pulses until INPUT.
  task automatic play_round(input int unsigned lvl, input logic [3:0] inject);
    logic [3:0] shown[$];
    bit reached;
    reached = 1'b0;
    bus.btn = inject;
    for (int i = 0; i < 4 * MaxLen + 8 && !reached; i++) begin
      @(negedge slow_clk);
      bus.btn = '0;
      if (bus.state == 3'd2) shown.push_back(bus.led);
      if (bus.state == 3'd4) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL round%0d_reach_input: state %0d, required 4", lvl, bus.state);
    end
    checks++;
    if (shown.size() != lvl || exp_seq.size() != lvl) begin
      errors++;
      $display("FAIL round%0d_show_count: shown %0d model %0d, required %0d", lvl,
               shown.size(), exp_seq.size(), lvl);
    end else begin
      for (int k = 0; k < int'(lvl); k++) begin
        checks++;
        if (shown[k] !== 4'(1 << exp_seq[k])) begin
          errors++;
          $display("FAIL round%0d_show_led%0d: led %b, required %b", lvl, k, shown[k],
                   4'(1 << exp_seq[k]));
        end
      end
    end
    checks++;
    if (bus.level !== 3'(lvl)) begin
      errors++;
      $display("FAIL round%0d_level: level %0d, required %0d", lvl, bus.level, lvl);
    end
  endtask

  // From IDLE, play correctly until INPUT of round `target`.
  task automatic start_game(input int unsigned target);
    repeat ($urandom_range(0, 15)) @(negedge slow_clk);
    press(4'(1 << $urandom_range(0, 3)));
    checks++;
    if (bus.state !== 3'd1) begin
      errors++;
      $display("FAIL start_add: state %0d, required 1", bus.state);
    end
    play_round(1, 4'b0000);
    for (int r = 1; r < int'(target); r++) begin
      for (int k = 0; k < r; k++) press(4'(1 << exp_seq[k]));
      checks++;
      if (bus.state !== 3'd1) begin
        errors++;
        $display("FAIL start_next_add%0d: state %0d, required 1", r, bus.state);
      end
      play_round(r + 1, 4'b0000);
    end
  endtask

  task automatic test_reset();
    bus.btn = '0;
    reset   = 1'b1;
    @(negedge slow_clk);
    @(negedge slow_clk);
    checks++;
    if ({bus.state, bus.led, bus.level, bus.error_led, bus.win_led} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: state %0d led %b level %0d err %b win %b, required all 0",
               bus.state, bus.led, bus.level, bus.error_led, bus.win_led);
    end
    reset = 1'b0;
    press(4'b0001);
    @(negedge slow_clk);
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("FAIL reset_reach_show: state %0d, required 2", bus.state);
    end
    #2 reset = 1'b1;
    @(negedge slow_clk);
    checks++;
    if ({bus.state, bus.led, bus.level, bus.error_led, bus.win_led} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_show: state %0d led %b level %0d err %b win %b, required all 0",
               bus.state, bus.led, bus.level, bus.error_led, bus.win_led);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_round();
    repeat ($urandom_range(0, 7)) @(negedge slow_clk);
    bus.btn = 4'b0001;
    @(negedge slow_clk);
    bus.btn = '0;
    @(negedge slow_clk);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL first_not_early: state %0d, required 0", bus.state);
    end
    @(negedge slow_clk);
    checks++;
    if (bus.state !== 3'd1 || bus.level !== 3'd0) begin
      errors++;
      $display("FAIL first_add: state %0d level %0d, required 1 and 0", bus.state, bus.level);
    end
    play_round(1, 4'b0000);
    checks++;
    if (bus.led !== 4'b0000) begin
      errors++;
      $display("FAIL first_input_led: led %b, required 0000", bus.led);
    end
  endtask

  task automatic test_win();
    for (int r = 1; r <= int'(MaxLen); r++) begin
      for (int k = 0; k < r; k++) press(4'(1 << exp_seq[k]));
      if (r < int'(MaxLen)) begin
        checks++;
        if (bus.state !== 3'd1) begin
          errors++;
          $display("FAIL win_round%0d_add: state %0d, required 1", r, bus.state);
        end
        play_round(r + 1, 4'b0000);
      end
    end
    checks++;
    if ({bus.state, bus.win_led, bus.led, bus.level, bus.error_led} !== {3'd6, 1'b1, 4'hF, 3'd4, 1'b0})
    begin
      errors++;
      $display("FAIL win_outputs: state %0d win %b led %b level %0d err %b, required 6 1 1111 4 0",
               bus.state, bus.win_led, bus.led, bus.level, bus.error_led);
    end
    press(4'(1 << $urandom_range(0, 3)));
    checks++;
    if ({bus.state, bus.level, bus.win_led, bus.led} !== {3'd0, 3'd0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL win_to_idle: state %0d level %0d win %b led %b, required all 0",
               bus.state, bus.level, bus.win_led, bus.led);
    end
  endtask

  task automatic test_fail();
    logic [1:0] wrong;
    start_game(2);
    press(4'(1 << exp_seq[0]));
    checks++;
    if (bus.state !== 3'd4) begin
      errors++;
      $display("FAIL fail_first_ok: state %0d, required 4", bus.state);
    end
    wrong = exp_seq[1] + 2'($urandom_range(1, 3));
    press(4'(1 << wrong));
    checks++;
    if ({bus.state, bus.error_led, bus.level, bus.led} !== {3'd5, 1'b1, 3'd2, 4'h0}) begin
      errors++;
      $display("FAIL fail_outputs: state %0d err %b level %0d led %b, required 5 1 2 0000",
               bus.state, bus.error_led, bus.level, bus.led);
    end
    press(4'(1 << $urandom_range(0, 3)));
    checks++;
    if ({bus.state, bus.error_led, bus.level} !== {3'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL fail_to_idle: state %0d err %b level %0d, required 0 0 0",
               bus.state, bus.error_led, bus.level);
    end
  endtask

  task automatic test_ignore_and_multi();
    start_game(1);
    press(4'(1 << exp_seq[0]));
    // Press lands while the sequence is being shown and must be dropped.
    play_round(2, 4'(1 << $urandom_range(0, 3)));
    for (int k = 0; k < 2; k++) press(4'(1 << exp_seq[k]));
    checks++;
    if (bus.state !== 3'd1) begin
      errors++;
      $display("FAIL ignore_show_press: state %0d, required 1", bus.state);
    end
    play_round(3, 4'b0000);
    press(4'b0011);
    checks++;
    if (bus.state !== 3'd5 || bus.error_led !== 1'b1) begin
      errors++;
      $display("FAIL multi_press: state %0d err %b, required 5 1", bus.state, bus.error_led);
    end
    press(4'b1000);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL multi_to_idle: state %0d, required 0", bus.state);
    end
  endtask

  task automatic test_timeout();
`ifdef SIMON_TIMEOUT_EN
    start_game(2);
    // At first INPUT cycle; a press raised now reaches the FSM in the last allowed cycle.
    repeat (5) @(negedge slow_clk);
    bus.btn = 4'(1 << exp_seq[0]);
    @(negedge slow_clk);
    bus.btn = '0;
    @(negedge slow_clk);
    @(negedge slow_clk);
    checks++;
    if (bus.state !== 3'd4) begin
      errors++;
      $display("FAIL tmo_press_wins: state %0d, required 4", bus.state);
    end
    repeat (TmoTicks - 1) @(negedge slow_clk);
    checks++;
    if (bus.state !== 3'd4) begin
      errors++;
      $display("FAIL tmo_cleared: state %0d, required 4", bus.state);
    end
    @(negedge slow_clk);
    checks++;
    if (bus.state !== 3'd5 || bus.level !== 3'd2) begin
      errors++;
      $display("FAIL tmo_expire: state %0d level %0d, required 5 2", bus.state, bus.level);
    end
`else
    start_game(1);
    repeat (100) @(negedge slow_clk);
    checks++;
    if (bus.state !== 3'd4 || bus.level !== 3'd1) begin
      errors++;
      $display("FAIL no_timeout: state %0d level %0d, required 4 1", bus.state, bus.level);
    end
`endif
  endtask

  initial begin
    bus.btn = '0;
    test_reset();
    test_first_round();
    test_win();
    test_fail();
    test_ignore_and_multi();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
